tnn_feature_packer: RTL and testbench



---
 rtl/tnn_pack_pkg.sv | 35 +++
 rtl/tnn_thr_regfile.sv | 49 ++++
 rtl/tnn_feature_packer.sv | 150 +++++++++++++++
 tb/tb_tnn_feature_packer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tnn_pack_pkg.sv
// Shared constants, types and the 2-bit quantizer for the TNN feature packer.
package tnn_pack_pkg;

    localparam int N_FEAT  = 6;
    localparam int RAW_W   = 8;
    localparam int Q_W     = 2;
    localparam int FRAME_W = N_FEAT * Q_W;
    localparam int IDX_W   = $clog2(N_FEAT);

    localparam logic [RAW_W-1:0] THR0_RST = 8'd64;
    localparam logic [RAW_W-1:0] THR1_RST = 8'd128;
    localparam logic [RAW_W-1:0] THR2_RST = 8'd192;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    typedef logic [N_FEAT-1:0][Q_W-1:0] slots_t;

    // Thresholds are tested in order and the first true compare wins,
    // so non-monotonic settings still give a defined code.
    function automatic logic [Q_W-1:0] quantize(
        input logic [RAW_W-1:0] d,
        input logic [RAW_W-1:0] t0,
        input logic [RAW_W-1:0] t1,
        input logic [RAW_W-1:0] t2
    );
        if (d < t0)      return 2'd0;
        else if (d < t1) return 2'd1;
        else if (d < t2) return 2'd2;
        else             return 2'd3;
    endfunction

endpackage

// File: rtl/tnn_thr_regfile.sv
// Three programmable quantization thresholds; index 3 writes are dropped.
module tnn_thr_regfile
    import tnn_pack_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             thr_we,
    input  logic [1:0]       thr_sel,
    input  logic [RAW_W-1:0] thr_data,
    output logic [RAW_W-1:0] t0,
    output logic [RAW_W-1:0] t1,
    output logic [RAW_W-1:0] t2
);

    logic [RAW_W-1:0] t0_q, t0_d;
    logic [RAW_W-1:0] t1_q, t1_d;
    logic [RAW_W-1:0] t2_q, t2_d;

    always_comb begin
        t0_d = t0_q;
        t1_d = t1_q;
        t2_d = t2_q;
        if (thr_we) begin
            case (thr_sel)
                2'd0:    t0_d = thr_data;
                2'd1:    t1_d = thr_data;
                2'd2:    t2_d = thr_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t0_q <= THR0_RST;
            t1_q <= THR1_RST;
            t2_q <= THR2_RST;
        end else begin
            t0_q <= t0_d;
            t1_q <= t1_d;
            t2_q <= t2_d;
        end
    end

    assign t0 = t0_q;
    assign t1 = t1_q;
    assign t2 = t2_q;

endmodule

// File: rtl/tnn_feature_packer.sv
// Quantizes a serial raw-feature stream to 2 bits and packs 6 codes per frame.
// Define TNN_PACK_DBUF_EN to add a second bank so collection continues while a frame waits.
module tnn_feature_packer
    import tnn_pack_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [RAW_W-1:0]   s_data,
    input  logic               s_last,
    input  logic               thr_we,
    input  logic [1:0]         thr_sel,
    input  logic [RAW_W-1:0]   thr_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [FRAME_W-1:0] m_data,
    output logic               err
);

    logic [RAW_W-1:0] t0, t1, t2;

    tnn_thr_regfile u_thr (
        .clk      (clk),
        .rst_n    (rst_n),
        .thr_we   (thr_we),
        .thr_sel  (thr_sel),
        .thr_data (thr_data),
        .t0       (t0),
        .t1       (t1),
        .t2       (t2)
    );

    state_e             state_q, state_d;
    slots_t             slots_q, slots_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               m_valid_q, m_valid_d;
    logic [FRAME_W-1:0] m_data_q, m_data_d;
    logic               err_q, err_d;
`ifdef TNN_PACK_DBUF_EN
    slots_t             pend_q, pend_d;
    logic               pend_valid_q, pend_valid_d;
`endif

    logic [Q_W-1:0] q_val;
    slots_t         frame_full;
    logic           last_slot, accept, frame_done, pop;

    always_comb begin
        // Thresholds are registered, so a same-cycle write is not yet visible here.
        q_val      = quantize(s_data, t0, t1, t2);
        last_slot  = (idx_q == IDX_W'(N_FEAT - 1));
        frame_full = slots_q;
        frame_full[idx_q] = q_val;
        pop        = m_valid_q & m_ready;
`ifdef TNN_PACK_DBUF_EN
        s_ready    = ~(pend_valid_q & m_valid_q & ~m_ready);
`else
        s_ready    = (state_q == COLLECT);
`endif
        accept     = s_valid & s_ready;
        frame_done = accept & last_slot;

        slots_d   = slots_q;
        idx_d     = idx_q;
        err_d     = err_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
`ifdef TNN_PACK_DBUF_EN
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
`endif

        // Alignment is by count: the sixth feature always closes a frame.
        if (accept) begin
            if (last_slot) begin
                idx_d = '0;
                if (!s_last) err_d = 1'b1;
            end else if (s_last) begin
                idx_d = '0;
                err_d = 1'b1;
            end else begin
                slots_d[idx_q] = q_val;
                idx_d          = idx_q + IDX_W'(1);
            end
        end

`ifdef TNN_PACK_DBUF_EN
        if (pop) begin
            if (pend_valid_q) begin
                m_data_d     = pend_q;
                pend_valid_d = frame_done;
                if (frame_done) pend_d = frame_full;
            end else if (frame_done) begin
                m_data_d = frame_full;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (frame_done) begin
            if (m_valid_q) begin
                pend_d       = frame_full;
                pend_valid_d = 1'b1;
            end else begin
                m_data_d  = frame_full;
                m_valid_d = 1'b1;
            end
        end
`else
        if (frame_done) begin
            m_data_d  = frame_full;
            m_valid_d = 1'b1;
        end else if (pop) begin
            m_valid_d = 1'b0;
        end
`endif

        state_d = m_valid_d ? HOLD : COLLECT;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= COLLECT;
            slots_q   <= '0;
            idx_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            err_q     <= 1'b0;
`ifdef TNN_PACK_DBUF_EN
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            slots_q   <= slots_d;
            idx_q     <= idx_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            err_q     <= err_d;
`ifdef TNN_PACK_DBUF_EN
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
`endif
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign err     = err_q;

endmodule

// File: tb/tb_tnn_feature_packer.sv
// Directed self-checking bench for tnn_feature_packer; inputs driven and outputs sampled on the falling edge.
module tb_tnn_feature_packer;
    import tnn_pack_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               s_valid;
    logic               s_ready;
    logic [RAW_W-1:0]   s_data;
    logic               s_last;
    logic               thr_we;
    logic [1:0]         thr_sel;
    logic [RAW_W-1:0]   thr_data;
    logic               m_valid;
    logic               m_ready;
    logic [FRAME_W-1:0] m_data;
    logic               err;

    int n_pass  = 0;
    int n_total = 0;

`ifdef TNN_PACK_DBUF_EN
    localparam logic DBUF = 1'b1;
`else
    localparam logic DBUF = 1'b0;
`endif

    logic [5:0][7:0] basic_vec;
    logic [5:0][7:0] fives_vec;
    logic [5:0][7:0] nonmono_vec;
    logic [5:0][7:0] second_vec;

    always #5 clk = ~clk;

    tnn_feature_packer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .thr_we   (thr_we),
        .thr_sel  (thr_sel),
        .thr_data (thr_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .err      (err)
    );

    task automatic send(input logic [7:0] d, input logic last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [5:0][7:0] v, input logic last6);
        for (int i = 0; i < 6; i++) send(v[i], (i == 5) ? last6 : 1'b0);
    endtask

    task automatic thr_write(input logic [1:0] sel, input logic [7:0] data);
        thr_we   = 1'b1;
        thr_sel  = sel;
        thr_data = data;
        @(negedge clk);
        thr_we   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_total++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready: got %b expected 1", s_ready); else n_pass++;
        n_total++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b expected 0", m_valid); else n_pass++;
        n_total++; if (m_data !== 12'h000) $display("FAIL reset_m_data: got %h expected 000", m_data); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_basic();
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(basic_vec[i], 1'b0);
        n_total++; if (m_valid !== 1'b0) $display("FAIL basic_early_valid: got %b expected 0", m_valid); else n_pass++;
        send(basic_vec[5], 1'b1);
        n_total++; if (m_valid !== 1'b1) $display("FAIL basic_valid: got %b expected 1", m_valid); else n_pass++;
        n_total++; if (m_data !== 12'hCE4) $display("FAIL basic_data: got %h expected ce4", m_data); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL basic_err: got %b expected 0", err); else n_pass++;
        n_total++; if (s_ready !== DBUF) $display("FAIL basic_hold_ready: got %b expected %b", s_ready, DBUF); else n_pass++;
        @(negedge clk);
        n_total++; if (m_valid !== 1'b0) $display("FAIL basic_pop_valid: got %b expected 0", m_valid); else n_pass++;
        n_total++; if (s_ready !== 1'b1) $display("FAIL basic_pop_ready: got %b expected 1", s_ready); else n_pass++;
        n_total++; if (m_data !== 12'hCE4) $display("FAIL basic_data_held: got %h expected ce4", m_data); else n_pass++;
        $display("test_basic done");
    endtask

    task automatic test_stall();
        m_ready = 1'b0;
        send_frame(basic_vec, 1'b1);
        for (int c = 0; c < 5; c++) begin
            n_total++; if (m_valid !== 1'b1) $display("FAIL stall_valid c%0d: got %b expected 1", c, m_valid); else n_pass++;
            n_total++; if (m_data !== 12'hCE4) $display("FAIL stall_data c%0d: got %h expected ce4", c, m_data); else n_pass++;
            n_total++; if (s_ready !== DBUF) $display("FAIL stall_ready c%0d: got %b expected %b", c, s_ready, DBUF); else n_pass++;
            @(negedge clk);
        end
        m_ready = 1'b1;
        #1;
        n_total++; if (s_ready !== DBUF) $display("FAIL stall_ready_bubble: got %b expected %b", s_ready, DBUF); else n_pass++;
        @(negedge clk);
        n_total++; if (m_valid !== 1'b0) $display("FAIL stall_pop_valid: got %b expected 0", m_valid); else n_pass++;
        n_total++; if (s_ready !== 1'b1) $display("FAIL stall_pop_ready: got %b expected 1", s_ready); else n_pass++;
        $display("test_stall done");
    endtask

    task automatic test_thr_write();
        m_ready  = 1'b1;
        thr_we   = 1'b1;
        thr_sel  = 2'd0;
        thr_data = 8'd0;
        send(8'd5, 1'b0);
        thr_we   = 1'b0;
        for (int i = 1; i < 6; i++) send(basic_vec[i], (i == 5));
        n_total++; if (m_data !== 12'hDE4) $display("FAIL thr_same_cycle: got %h expected de4", m_data); else n_pass++;
        @(negedge clk);
        send_frame(fives_vec, 1'b1);
        n_total++; if (m_data !== 12'h555) $display("FAIL thr_new_t0: got %h expected 555", m_data); else n_pass++;
        @(negedge clk);
        thr_write(2'd0, 8'd64);
        thr_write(2'd3, 8'd0);
        thr_write(2'd2, 8'd100);
        send_frame(nonmono_vec, 1'b1);
        n_total++; if (m_data !== 12'h5F4) $display("FAIL thr_nonmono: got %h expected 5f4", m_data); else n_pass++;
        @(negedge clk);
        thr_write(2'd2, 8'd192);
        $display("test_thr_write done");
    endtask

    task automatic test_partial();
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(basic_vec[i], (i == 2));
        n_total++; if (m_valid !== 1'b0) $display("FAIL partial_valid: got %b expected 0", m_valid); else n_pass++;
        n_total++; if (err !== 1'b1) $display("FAIL partial_err: got %b expected 1", err); else n_pass++;
        repeat (3) @(negedge clk);
        n_total++; if (m_valid !== 1'b0) $display("FAIL partial_no_frame: got %b expected 0", m_valid); else n_pass++;
        send_frame(basic_vec, 1'b1);
        n_total++; if (m_valid !== 1'b1) $display("FAIL partial_next_valid: got %b expected 1", m_valid); else n_pass++;
        n_total++; if (m_data !== 12'hCE4) $display("FAIL partial_next_data: got %h expected ce4", m_data); else n_pass++;
        n_total++; if (err !== 1'b1) $display("FAIL partial_err_sticky: got %b expected 1", err); else n_pass++;
        @(negedge clk);
        $display("test_partial done");
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b1;
        thr_write(2'd0, 8'd0);
        for (int i = 0; i < 4; i++) send(basic_vec[i], 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_total++; if (s_ready !== 1'b1) $display("FAIL rstmid_s_ready: got %b expected 1", s_ready); else n_pass++;
        n_total++; if (m_valid !== 1'b0) $display("FAIL rstmid_m_valid: got %b expected 0", m_valid); else n_pass++;
        n_total++; if (m_data !== 12'h000) $display("FAIL rstmid_m_data: got %h expected 000", m_data); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL rstmid_err: got %b expected 0", err); else n_pass++;
        send_frame(basic_vec, 1'b1);
        n_total++; if (m_valid !== 1'b1) $display("FAIL rstmid_frame_valid: got %b expected 1", m_valid); else n_pass++;
        n_total++; if (m_data !== 12'hCE4) $display("FAIL rstmid_frame_data: got %h expected ce4", m_data); else n_pass++;
        @(negedge clk);
        $display("test_reset_mid done");
    endtask

    task automatic test_missing_last();
        m_ready = 1'b1;
        send_frame(basic_vec, 1'b0);
        n_total++; if (m_valid !== 1'b1) $display("FAIL nolast_valid: got %b expected 1", m_valid); else n_pass++;
        n_total++; if (m_data !== 12'hCE4) $display("FAIL nolast_data: got %h expected ce4", m_data); else n_pass++;
        n_total++; if (err !== 1'b1) $display("FAIL nolast_err: got %b expected 1", err); else n_pass++;
        @(negedge clk);
        $display("test_missing_last done");
    endtask

`ifdef TNN_PACK_DBUF_EN
    task automatic test_back_to_back();
        m_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            n_total++; if (s_ready !== 1'b1) $display("FAIL b2b_ready f%0d: got %b expected 1", i, s_ready); else n_pass++;
            send((i < 6) ? basic_vec[i] : second_vec[i-6], (i == 5) || (i == 11));
        end
        n_total++; if (s_ready !== 1'b0) $display("FAIL b2b_full_ready: got %b expected 0", s_ready); else n_pass++;
        n_total++; if (m_valid !== 1'b1) $display("FAIL b2b_first_valid: got %b expected 1", m_valid); else n_pass++;
        n_total++; if (m_data !== 12'hCE4) $display("FAIL b2b_first_data: got %h expected ce4", m_data); else n_pass++;
        m_ready = 1'b1;
        @(negedge clk);
        n_total++; if (m_valid !== 1'b1) $display("FAIL b2b_second_valid: got %b expected 1", m_valid); else n_pass++;
        n_total++; if (m_data !== 12'h393) $display("FAIL b2b_second_data: got %h expected 393", m_data); else n_pass++;
        @(negedge clk);
        n_total++; if (m_valid !== 1'b0) $display("FAIL b2b_drained: got %b expected 0", m_valid); else n_pass++;
        $display("test_back_to_back done");
    endtask
`endif

    initial begin
        basic_vec   = {8'd255, 8'd63, 8'd200, 8'd130, 8'd70, 8'd10};
        fives_vec   = {8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5};
        nonmono_vec = {8'd127, 8'd64, 8'd200, 8'd150, 8'd110, 8'd10};
        second_vec  = {8'd1, 8'd192, 8'd128, 8'd64, 8'd0, 8'd255};
        s_valid  = 1'b0;
        s_data   = '0;
        s_last   = 1'b0;
        thr_we   = 1'b0;
        thr_sel  = '0;
        thr_data = '0;
        m_ready  = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_thr_write();
        test_partial();
        test_reset_mid();
        test_missing_last();
`ifdef TNN_PACK_DBUF_EN
        test_back_to_back();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
